// File: rtl/lvt_pkg.sv
// Shared definitions for the live-value-table memory.
// The read port and the write-side bank allocator both import this package.
package lvt_pkg;

  localparam int LVT_INDEX_WIDTH = 8;
  localparam int LVT_R           = 4;
  localparam int LVT_N_BITS_R    = 2;
  localparam int LVT_DATA_WIDTH  = 32;

  // One live-table entry: which bank holds the current value, and whether
  // the address has been written at all since reset.
  typedef struct packed {
    logic                    valid;
    logic [LVT_N_BITS_R-1:0] bank;
  } live_entry_t;

endpackage

// File: rtl/lvt_rsp_fifo.sv
// Two-entry response FIFO between the bank mux and the response port.
// The head is shown combinationally and forced to zero when the FIFO is empty.
// A push into a full FIFO is legal only together with a pop in the same cycle.
module lvt_rsp_fifo #(
  parameter int width = 33
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [width-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [width-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [width-1:0] r_mem [2];
  logic             r_wrPtr;
  logic             r_rdPtr;
  logic [1:0]       r_count;
  logic             w_pop;

  assign w_pop   = i_pop && (r_count != 2'd0);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = o_valid ? r_mem[r_rdPtr] : '0;
  assign o_count = r_count;

  // Pointer and occupancy bookkeeping; reset empties the FIFO immediately.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) r_wrPtr <= ~r_wrPtr;
      if (w_pop)  r_rdPtr <= ~r_rdPtr;
      if (i_push && !w_pop)      r_count <= r_count + 2'd1;
      else if (!i_push && w_pop) r_count <= r_count - 2'd1;
    end
  end

  // Storage needs no reset: an entry is only visible once it has been pushed.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/lvt_read_port.sv
// Read side of the LVT multi-bank memory.
// Looks up the live bank for each read, broadcasts the address to every bank,
// then picks the live bank's data one cycle later and queues it for the consumer.
// Reads are credit-limited so that the banks, which cannot stall, never overrun
// the two-entry response FIFO.
module lvt_read_port
  import lvt_pkg::*;
#(
  parameter int index_width = LVT_INDEX_WIDTH,
  parameter int r           = LVT_R,
  parameter int n_bits_r    = LVT_N_BITS_R,
  parameter int data_width  = LVT_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    upd_en,
  input  logic [index_width-1:0]  upd_addr,
  input  logic [n_bits_r-1:0]     upd_bank,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [index_width-1:0]  rd_addr,
  output logic                    bank_rd_en,
  output logic [index_width-1:0]  bank_rd_addr,
  input  logic [r*data_width-1:0] bank_rd_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [data_width-1:0]   rsp_data,
  output logic                    rsp_hit
);

  localparam int DEPTH = 1 << index_width;

  live_entry_t           r_table [DEPTH];
  live_entry_t           r_capEntry;
  logic                  r_inflight;
  live_entry_t           w_lookup;
  logic                  w_accept;
  logic [1:0]            w_fifoCount;
  logic [data_width-1:0] w_selData;
  logic                  w_selHit;
  logic [data_width:0]   w_pushData;
  logic [data_width:0]   w_headData;

  assign w_accept     = rd_valid && rd_ready;
  assign bank_rd_en   = w_accept;
  assign bank_rd_addr = rd_addr;
  assign rd_ready     = ({1'b0, w_fifoCount} + {2'b00, r_inflight}) < 3'd2;

  // Live table: every write from the allocator marks its address live in the given bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_table <= '{default: '0};
    end else if (upd_en) begin
      r_table[upd_addr] <= '{valid: 1'b1, bank: upd_bank};
    end
  end

  // Table lookup with bypass, so a read colliding with a same-cycle write sees the new bank.
  always_comb begin
    w_lookup = r_table[rd_addr];
    if (upd_en && (upd_addr == rd_addr)) begin
      w_lookup = '{valid: 1'b1, bank: upd_bank};
    end
  end

  // Capture the live entry for the accepted read while the banks perform their access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inflight <= 1'b0;
      r_capEntry <= '0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) r_capEntry <= w_lookup;
    end
  end

  // Bank mux: a miss or a bank index beyond the populated banks yields zero data and no hit.
  always_comb begin
    w_selData = '0;
    w_selHit  = 1'b0;
    for (int k = 0; k < r; k++) begin
      if (r_capEntry.valid && (r_capEntry.bank == n_bits_r'(k))) begin
        w_selData = bank_rd_data[k*data_width +: data_width];
        w_selHit  = 1'b1;
      end
    end
  end

  assign w_pushData = {w_selHit, w_selData};

  lvt_rsp_fifo #(
    .width(data_width + 1)
  ) u_rspFifo (
    .clk    (clk),
    .i_rst_n(reset),
    .i_push (r_inflight),
    .i_data (w_pushData),
    .i_pop  (rsp_ready),
    .o_valid(rsp_valid),
    .o_data (w_headData),
    .o_count(w_fifoCount)
  );

  assign rsp_hit  = w_headData[data_width];
  assign rsp_data = w_headData[data_width-1:0];

endmodule

// File: tb/tb_lvt_read_port.sv
// Directed bench for lvt_read_port with a one-cycle-latency bank model.
// Bank k returns k*32'h1111 on the cycle after a read enable, and junk otherwise.
module tb_lvt_read_port;

  logic         clk;
  logic         reset;
  logic         upd_en;
  logic [7:0]   upd_addr;
  logic [1:0]   upd_bank;
  logic         rd_valid;
  logic         rd_ready;
  logic [7:0]   rd_addr;
  logic         bank_rd_en;
  logic [7:0]   bank_rd_addr;
  logic [127:0] bank_rd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_data;
  logic         rsp_hit;

  int total = 0;
  int bad   = 0;

  logic [7:0]  reqAddr [8];
  logic [31:0] gotData [8];
  logic        gotHit  [8];
  int          gotCount;
  int          stallSent;
  logic        stallReady;
  logic        stallValid;
  logic [31:0] stallData;

  lvt_read_port dut (
    .clk         (clk),
    .reset       (reset),
    .upd_en      (upd_en),
    .upd_addr    (upd_addr),
    .upd_bank    (upd_bank),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_addr     (rd_addr),
    .bank_rd_en  (bank_rd_en),
    .bank_rd_addr(bank_rd_addr),
    .bank_rd_data(bank_rd_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_hit     (rsp_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: valid data only in the cycle following a read enable.
  always @(posedge clk) begin
    if (bank_rd_en) bank_rd_data <= {32'h3333_3333 & 32'h0000_3333, 32'h0000_2222, 32'h0000_1111, 32'h0000_0000};
    else            bank_rd_data <= {4{32'hBAD0_BAD0}};
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One live-table write lasting a single cycle.
  task automatic applyStimulus(input logic [7:0] addr, input logic [1:0] bank);
    upd_en   = 1'b1;
    upd_addr = addr;
    upd_bank = bank;
    tick();
    upd_en   = 1'b0;
  endtask

  // Issue n reads from reqAddr and collect n responses; rsp_ready is held low for the first stall cycles.
  task automatic runReads(input int n, input int stall);
    int sent = 0;
    int cyc  = 0;
    gotCount  = 0;
    rsp_ready = (stall == 0);
    while ((sent < n || gotCount < n) && cyc < 40) begin
      if (stall > 0 && cyc == stall) begin
        stallSent  = sent;
        stallReady = rd_ready;
        stallValid = rsp_valid;
        stallData  = rsp_data;
        rsp_ready  = 1'b1;
      end
      rd_valid = (sent < n);
      if (sent < n) rd_addr = reqAddr[sent];
      #1;
      if (rd_valid && rd_ready) sent++;
      if (rsp_valid && rsp_ready && gotCount < 8) begin
        gotData[gotCount] = rsp_data;
        gotHit[gotCount]  = rsp_hit;
        gotCount++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    rd_valid  = 1'b0;
    rsp_ready = 1'b1;
    checkOutput("readsCompleted", 64'(gotCount), 64'(n));
  endtask

  initial begin
    reset     = 1'b0;
    upd_en    = 1'b0;
    upd_addr  = '0;
    upd_bank  = '0;
    rd_valid  = 1'b0;
    rd_addr   = '0;
    rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstRspValid", rsp_valid, 0);
    checkOutput("rstBankRdEn", bank_rd_en, 0);
    reset = 1'b1;
    #1;
    checkOutput("rstRdReady", rd_ready, 1);
    checkOutput("rstRspData", rsp_data, 0);
    checkOutput("rstRspHit", rsp_hit, 0);

    // 1: read of an unwritten address, two-cycle latency
    tick();
    rd_valid = 1'b1;
    rd_addr  = 8'd5;
    #1;
    checkOutput("t1BankRdEn", bank_rd_en, 1);
    checkOutput("t1BankRdAddr", bank_rd_addr, 8'd5);
    checkOutput("t1RdReadyE0", rd_ready, 1);
    tick();
    rd_valid = 1'b0;
    checkOutput("t1RspValidE0", rsp_valid, 0);
    checkOutput("t1RdReadyE1", rd_ready, 1);
    tick();
    checkOutput("t1RspValidE1", rsp_valid, 1);
    checkOutput("t1RspHit", rsp_hit, 0);
    checkOutput("t1RspData", rsp_data, 0);
    checkOutput("t1RdReadyE2", rd_ready, 1);
    tick();
    checkOutput("t1RspPopped", rsp_valid, 0);

    // 2: written address returns the live bank's data
    applyStimulus(8'd5, 2'd2);
    reqAddr[0] = 8'd5;
    runReads(1, 0);
    checkOutput("t2Hit", gotHit[0], 1);
    checkOutput("t2Data", gotData[0], 32'h2222);

    // 3: same-cycle update and read take the bypass path
    applyStimulus(8'd9, 2'd1);
    upd_en   = 1'b1;
    upd_addr = 8'd9;
    upd_bank = 2'd3;
    rd_valid = 1'b1;
    rd_addr  = 8'd9;
    #1;
    checkOutput("t3RdReady", rd_ready, 1);
    tick();
    upd_en   = 1'b0;
    rd_valid = 1'b0;
    tick();
    checkOutput("t3RspValid", rsp_valid, 1);
    checkOutput("t3Hit", rsp_hit, 1);
    checkOutput("t3Data", rsp_data, 32'h3333);
    tick();
    reqAddr[0] = 8'd9;
    runReads(1, 0);
    checkOutput("t3AfterData", gotData[0], 32'h3333);

    // 4: back-pressure limits acceptance to two, then order is preserved
    applyStimulus(8'd20, 2'd1);
    applyStimulus(8'd21, 2'd2);
    applyStimulus(8'd22, 2'd3);
    applyStimulus(8'd23, 2'd0);
    reqAddr[0] = 8'd20;
    reqAddr[1] = 8'd21;
    reqAddr[2] = 8'd22;
    reqAddr[3] = 8'd23;
    runReads(4, 4);
    checkOutput("t4AcceptedInStall", 64'(stallSent), 2);
    checkOutput("t4RdReadyInStall", stallReady, 0);
    checkOutput("t4RspValidInStall", stallValid, 1);
    checkOutput("t4RspHeldInStall", stallData, 32'h1111);
    checkOutput("t4Data0", gotData[0], 32'h1111);
    checkOutput("t4Data1", gotData[1], 32'h2222);
    checkOutput("t4Data2", gotData[2], 32'h3333);
    checkOutput("t4Data3", gotData[3], 32'h0000);
    checkOutput("t4Hit3", gotHit[3], 1);
    tick();
    checkOutput("t4NoExtraRsp", rsp_valid, 0);

    // 5: top address is an ordinary entry and does not alias address 0
    applyStimulus(8'd255, 2'd1);
    reqAddr[0] = 8'd255;
    reqAddr[1] = 8'd0;
    runReads(2, 0);
    checkOutput("t5Hit255", gotHit[0], 1);
    checkOutput("t5Data255", gotData[0], 32'h1111);
    checkOutput("t5Hit0", gotHit[1], 0);
    checkOutput("t5Data0", gotData[1], 0);

    // 6: reset with two responses queued discards them and clears the table
    rsp_ready = 1'b0;
    rd_valid  = 1'b1;
    rd_addr   = 8'd5;
    tick();
    rd_addr   = 8'd9;
    tick();
    rd_valid  = 1'b0;
    tick();
    tick();
    checkOutput("t6QueuedValid", rsp_valid, 1);
    checkOutput("t6QueuedRdReady", rd_ready, 0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6AsyncRspValid", rsp_valid, 0);
    checkOutput("t6AsyncRspData", rsp_data, 0);
    tick();
    reset     = 1'b1;
    rsp_ready = 1'b1;
    #1;
    checkOutput("t6PostRspValid", rsp_valid, 0);
    checkOutput("t6PostRdReady", rd_ready, 1);
    tick();
    reqAddr[0] = 8'd5;
    reqAddr[1] = 8'd9;
    runReads(2, 0);
    checkOutput("t6Hit5", gotHit[0], 0);
    checkOutput("t6Data5", gotData[0], 0);
    checkOutput("t6Hit9", gotHit[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
